// File: rtl/pwm_generator_ch.sv
// pwm_generator_ch: prescaled PWM generator with a valid/ready shadowed duty load applied at
// period boundaries, offset floor, deadband, optional signed input with direction output and
// optional per-period slew limiting of the applied compare value.
module pwm_generator_ch #(
    parameter int unsigned WIDTH     = 10,
    parameter int unsigned CNT_W     = 16,
    parameter int unsigned PRESCALE  = 128,
    parameter int unsigned PERIOD    = 531,
    parameter int unsigned OFFSET    = 250,
    parameter int unsigned DEADBAND  = 12,
    parameter bit          SIGNED_IN = 1'b0,
    parameter int unsigned SLEW_STEP = 0
) (
    input  logic             CLOCK_50,
    input  logic             RESET_n,
    input  logic             en,
    input  logic [WIDTH-1:0] duty_in,
    input  logic             duty_valid,
    output logic             duty_ready,
    output logic             PWMout,
    output logic             dir,
    output logic             period_start,
    output logic [CNT_W-1:0] cmp_applied
);
    localparam int unsigned      PcW     = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PcW-1:0]   PcMax   = PcW'(PRESCALE - 1);
    localparam logic [CNT_W-1:0] CntMax  = CNT_W'(PERIOD - 1);
    localparam logic [CNT_W-1:0] PeriodC = CNT_W'(PERIOD);
    localparam logic [CNT_W-1:0] SlewC   = CNT_W'(SLEW_STEP);
    localparam logic [CNT_W:0]   OffsetX = (CNT_W + 1)'(OFFSET);
    localparam logic [CNT_W:0]   DeadX   = (CNT_W + 1)'(DEADBAND);
    localparam logic [CNT_W:0]   PeriodX = (CNT_W + 1)'(PERIOD);

    logic [PcW-1:0]   pcnt_q, pcnt_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] shadow_q, shadow_d;
    logic             full_q, full_d;
    logic [CNT_W-1:0] target_q, target_d;
    logic             tsign_q, tsign_d;
    logic [CNT_W-1:0] applied_q, applied_d;
    logic             dir_q, dir_d;
    logic             pwm_q, pwm_d;
    logic             ps_q, ps_d;

    logic             tick, boundary;
    logic             sh_neg, sgn_sel;
    logic [WIDTH-1:0] sh_mag;
    logic [CNT_W:0]   mag_x, sum_x;
    logic [CNT_W-1:0] tgt_new, tgt_sel;

    // Move cur toward goal by at most SLEW_STEP.
    function automatic logic [CNT_W-1:0] slew(input logic [CNT_W-1:0] cur,
                                              input logic [CNT_W-1:0] goal);
        logic [CNT_W-1:0] gap;
        if (goal >= cur) begin
            gap = goal - cur;
            return (gap > SlewC) ? cur + SlewC : goal;
        end else begin
            gap = cur - goal;
            return (gap > SlewC) ? cur - SlewC : goal;
        end
    endfunction

    assign tick     = (pcnt_q == PcMax);
    assign boundary = en && tick && (cnt_q == CntMax);

    // Derive the target compare from the shadowed duty; the sum is one bit wider so it never wraps.
    always_comb begin
        sh_neg = SIGNED_IN && shadow_q[WIDTH-1];
        sh_mag = sh_neg ? (~shadow_q + WIDTH'(1)) : shadow_q;
        mag_x  = (CNT_W + 1)'(sh_mag);
        sum_x  = mag_x + OffsetX;
        if (mag_x <= DeadX) begin
            tgt_new = '0;
        end else if (sum_x > PeriodX) begin
            tgt_new = PeriodC;
        end else begin
            tgt_new = sum_x[CNT_W-1:0];
        end
        tgt_sel = full_q ? tgt_new : target_q;
        sgn_sel = full_q ? sh_neg : tsign_q;
    end

    // Next-state: prescaler, period counter, handshake, boundary update of target/applied/dir.
    always_comb begin
        pcnt_d    = pcnt_q;
        cnt_d     = cnt_q;
        shadow_d  = shadow_q;
        full_d    = full_q;
        target_d  = target_q;
        tsign_d   = tsign_q;
        applied_d = applied_q;
        dir_d     = dir_q;
        ps_d      = 1'b0;

        // Handshake stays live even while disabled.
        if (duty_valid && !full_q) begin
            shadow_d = duty_in;
            full_d   = 1'b1;
        end

        if (!en) begin
            pcnt_d    = '0;
            cnt_d     = '0;
            target_d  = '0;
            tsign_d   = 1'b0;
            applied_d = '0;
            dir_d     = 1'b0;
        end else begin
            pcnt_d = tick ? '0 : pcnt_q + PcW'(1);
            if (tick) begin
                cnt_d = (cnt_q == CntMax) ? '0 : cnt_q + CNT_W'(1);
            end
            if (boundary) begin
                ps_d     = 1'b1;
                target_d = tgt_sel;
                tsign_d  = sgn_sel;
                if (full_q) begin
                    full_d = 1'b0;
                end
                if (tgt_sel == '0) begin
                    applied_d = '0;
                    dir_d     = sgn_sel;
                end else if (SLEW_STEP == 0) begin
                    applied_d = tgt_sel;
                    dir_d     = sgn_sel;
                end else if (sgn_sel != dir_q) begin
                    // Reverse only after ramping down to zero.
                    if (applied_q == '0) begin
                        dir_d     = sgn_sel;
                        applied_d = slew('0, tgt_sel);
                    end else begin
                        applied_d = slew(applied_q, '0);
                    end
                end else begin
                    applied_d = slew(applied_q, tgt_sel);
                end
            end
        end

        // Compare against next-state values so PWMout lines up with the registered counter.
        pwm_d = en && (cnt_d < applied_d);
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge CLOCK_50 or negedge RESET_n) begin
        if (!RESET_n) begin
            pcnt_q    <= '0;
            cnt_q     <= '0;
            shadow_q  <= '0;
            full_q    <= 1'b0;
            target_q  <= '0;
            tsign_q   <= 1'b0;
            applied_q <= '0;
            dir_q     <= 1'b0;
            pwm_q     <= 1'b0;
            ps_q      <= 1'b0;
        end else begin
            pcnt_q    <= pcnt_d;
            cnt_q     <= cnt_d;
            shadow_q  <= shadow_d;
            full_q    <= full_d;
            target_q  <= target_d;
            tsign_q   <= tsign_d;
            applied_q <= applied_d;
            dir_q     <= dir_d;
            pwm_q     <= pwm_d;
            ps_q      <= ps_d;
        end
    end

    assign duty_ready   = ~full_q;
    assign PWMout       = pwm_q;
    assign dir          = dir_q;
    assign period_start = ps_q;
    assign cmp_applied  = applied_q;

endmodule

// File: tb/tb_pwm_generator_ch.sv
// Bench for pwm_generator_ch: three instances (plain, slew-limited, signed) sharing clock/reset.
module tb_pwm_generator_ch;
    localparam int W = 8;

    logic         clk   = 1'b0;
    logic         rst_n = 1'b0;
    logic [2:0]   en_v, valid_v, ready_v, pwm_v, dir_v, ps_v;
    logic [W-1:0] duty_v [3];
    logic [15:0]  cmp_v  [3];
    int           checks   = 0;
    int           failures = 0;

    typedef struct {
        logic [W-1:0] duty;
        int           cmp;
        int           highs;
    } vec_t;
    vec_t vecs [9];

    always #5 clk = ~clk;

    // 0: plain, 1: SLEW_STEP=3, 2: SIGNED_IN=1
    for (genvar g = 0; g < 3; g++) begin : g_dut
        pwm_generator_ch #(
            .WIDTH    (W),
            .CNT_W    (16),
            .PRESCALE (2),
            .PERIOD   (20),
            .OFFSET   (5),
            .DEADBAND (2),
            .SIGNED_IN(g == 2),
            .SLEW_STEP((g == 1) ? 3 : 0)
        ) u_dut (
            .CLOCK_50    (clk),
            .RESET_n     (rst_n),
            .en          (en_v[g]),
            .duty_in     (duty_v[g]),
            .duty_valid  (valid_v[g]),
            .duty_ready  (ready_v[g]),
            .PWMout      (pwm_v[g]),
            .dir         (dir_v[g]),
            .period_start(ps_v[g]),
            .cmp_applied (cmp_v[g])
        );
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Wait for the next period_start of instance i; n = negedges waited.
    task automatic wait_ps(input int i, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!ps_v[i] && n < 200);
        if (!ps_v[i]) begin
            checks++;
            failures++;
            $display("FAIL wait_ps[%0d]: no period_start within %0d cycles", i, n);
        end
    endtask

    // Called on a period_start negedge; counts high cycles up to the next period_start.
    task automatic measure(input int i, output int highs, output int len);
        highs = 0;
        len   = 0;
        do begin
            highs += int'(pwm_v[i]);
            len++;
            @(negedge clk);
        end while (!ps_v[i] && len < 200);
    endtask

    task automatic load(input int i, input logic [W-1:0] d);
        duty_v[i]  = d;
        valid_v[i] = 1'b1;
        @(negedge clk);
        valid_v[i] = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, hi, len, prev;
        int slew_exp [8] = '{3, 6, 9, 12, 15, 18, 20, 20};

        en_v    = 3'b111;
        valid_v = 3'b000;
        for (int i = 0; i < 3; i++) duty_v[i] = '0;
        vecs[0] = '{8'd7,   12, 24};
        vecs[1] = '{8'd2,   0,  0};
        vecs[2] = '{8'd30,  20, 40};
        vecs[3] = '{8'd3,   8,  16};
        vecs[4] = '{8'd15,  20, 40};
        vecs[5] = '{8'd14,  19, 38};
        vecs[6] = '{8'd1,   0,  0};
        vecs[7] = '{8'd255, 20, 40};
        vecs[8] = '{8'd0,   0,  0};

        // Reset state and idle period timing
        step(3);
        check("rst_pwm",   int'(pwm_v[0]),   0);
        check("rst_ready", int'(ready_v[0]), 1);
        check("rst_ps",    int'(ps_v[0]),    0);
        check("rst_cmp",   int'(cmp_v[0]),   0);
        check("rst_dir",   int'(dir_v[2]),   0);
        rst_n = 1'b1;
        wait_ps(0, n);
        check("first_ps_gap", n, 40);
        measure(0, hi, len);
        check("idle_highs", hi, 0);
        check("idle_len", len, 40);

        // Table: load mid-period, applied only at the next wrap
        prev = 0;
        for (int v = 0; v < 9; v++) begin
            step(10);
            load(0, vecs[v].duty);
            check($sformatf("v%0d_ready_low", v), int'(ready_v[0]), 0);
            check($sformatf("v%0d_cmp_hold", v), int'(cmp_v[0]), prev);
            wait_ps(0, n);
            check($sformatf("v%0d_cmp", v), int'(cmp_v[0]), vecs[v].cmp);
            check($sformatf("v%0d_dir", v), int'(dir_v[0]), 0);
            measure(0, hi, len);
            check($sformatf("v%0d_highs", v), hi, vecs[v].highs);
            check($sformatf("v%0d_len", v), len, 40);
            prev = vecs[v].cmp;
        end

        // Second valid while shadow full is held off until after the wrap
        step(5);
        duty_v[0]  = 8'd3;
        valid_v[0] = 1'b1;
        @(negedge clk);
        check("hs_first_taken", int'(ready_v[0]), 0);
        duty_v[0] = 8'd9;
        @(negedge clk);
        check("hs_blocked", int'(ready_v[0]), 0);
        wait_ps(0, n);
        check("hs_cmp_first", int'(cmp_v[0]), 8);
        check("hs_ready_after_wrap", int'(ready_v[0]), 1);
        @(negedge clk);
        check("hs_second_taken", int'(ready_v[0]), 0);
        valid_v[0] = 1'b0;
        wait_ps(0, n);
        check("hs_cmp_second", int'(cmp_v[0]), 14);

        // Enable low: output and applied clear, handshake still live, restart from zero
        step(2);
        check("en_pre_high", int'(pwm_v[0]), 1);
        en_v[0] = 1'b0;
        step(1);
        check("en_off_pwm", int'(pwm_v[0]), 0);
        check("en_off_cmp", int'(cmp_v[0]), 0);
        load(0, 8'd7);
        check("en_off_load", int'(ready_v[0]), 0);
        step(3);
        check("en_off_pwm2", int'(pwm_v[0]), 0);
        en_v[0] = 1'b1;
        wait_ps(0, n);
        check("en_restart_gap", n, 40);
        check("en_restart_cmp", int'(cmp_v[0]), 12);

        // Slew-limited ramp, then immediate stop
        wait_ps(1, n);
        step(10);
        load(1, 8'd15);
        check("slew_ready_low", int'(ready_v[1]), 0);
        for (int k = 0; k < 8; k++) begin
            wait_ps(1, n);
            check($sformatf("slew_cmp%0d", k), int'(cmp_v[1]), slew_exp[k]);
        end
        step(10);
        load(1, 8'd0);
        wait_ps(1, n);
        check("slew_stop_cmp", int'(cmp_v[1]), 0);
        check("slew_stop_pwm", int'(pwm_v[1]), 0);

        // Signed input: most-negative, then -7; async reset mid-high
        wait_ps(2, n);
        step(10);
        load(2, 8'h80);
        wait_ps(2, n);
        check("sgn_min_dir", int'(dir_v[2]), 1);
        check("sgn_min_cmp", int'(cmp_v[2]), 20);
        step(10);
        load(2, 8'hF9);
        wait_ps(2, n);
        check("sgn_m7_dir", int'(dir_v[2]), 1);
        check("sgn_m7_cmp", int'(cmp_v[2]), 12);
        measure(2, hi, len);
        check("sgn_m7_highs", hi, 24);
        check("sgn_m7_len", len, 40);
        step(4);
        check("sgn_pre_reset_pwm", int'(pwm_v[2]), 1);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_pwm",   int'(pwm_v[2]),   0);
        check("async_rst_cmp",   int'(cmp_v[2]),   0);
        check("async_rst_dir",   int'(dir_v[2]),   0);
        check("async_rst_ready", int'(ready_v[2]), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
